alu_decode_stage: RTL and testbench
===================================

Name: alu_decode_stage

Overview:
Decode/operand-fetch stage directly upstream of the ALU. Accepts one RV32I OP / OP-IMM instruction per handshake and reads a 32x32 register file. Drives the ALU's rs1, rs2 and mode inputs from a registered pipeline slot, plus the destination index for writeback. The writeback stage downstream of the ALU writes results back through the wb_* port.

Parameters:
XLEN, 32, operand/data width.
NREG, 32, register count; register 0 is hardwired to zero.

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  instr is valid
in_ready  out  1  stage can accept instr this cycle
instr  in  32  RV32I instruction word
out_valid  out  1  output slot holds a decoded instruction
out_ready  in  1  ALU side consumes the slot this cycle
rs1  out  XLEN  operand A to ALU
rs2  out  XLEN  operand B to ALU (register or sign-extended immediate)
mode  out  4  ALU operation, ALU_OP_* macro codes
rd_addr  out  5  destination register index
illegal  out  1  slot holds an unsupported or illegal encoding
wb_en  in  1  register-file write enable
wb_addr  in  5  write index
wb_data  in  XLEN  write data

Behaviour:
- Reset (async): out_valid=0, rs1=rs2=0, mode=ALU_OP_ADD, rd_addr=0, illegal=0, all registers cleared to 0.
- in_ready = !out_valid || out_ready (combinational). An instruction is accepted when in_valid && in_ready; the slot loads on that edge, so latency is 1 cycle.
- Slot drains when out_valid && out_ready. If nothing is accepted on that edge, out_valid becomes 0. Simultaneous drain and accept: the slot reloads and out_valid stays 1.
- While out_valid && !out_ready, all outputs hold stable, except for the hazard-update rule below.
- Register file:
  - Writes on the clock edge when wb_en=1 and wb_addr!=0; writes to x0 are ignored.
  - Reads of x0 always return 0.
  - Write-through bypass: if the read index equals wb_addr, wb_en=1 and the index is non-zero in the accept cycle, the operand takes wb_data.
- Hazard update: while the slot is held (out_valid=1, not draining), a write to a non-zero register matching the held instruction's rs1 field updates rs1. The same applies to rs2, but only for register-sourced rs2 (OP format).
- OP (opcode 0110011), funct7 in {0000000, 0100000}:
  - funct3 000: ADD, or SUB when funct7=0100000.
  - 001: SLL. 010: SLT. 011: SLTU. 100: XOR.
  - 101: SRL, or SRA when funct7=0100000.
  - 110: OR. 111: AND.
  - funct7=0100000 with funct3 not in {000, 101}: illegal.
- OP-IMM (opcode 0010011):
  - rs2 = sign-extended imm[11:0]; mode follows funct3 as above. No SUB form. SLTIU compares the sign-extended value unsigned.
  - SLLI requires imm[11:5]=0000000.
  - SRLI/SRAI require imm[11:5]=0000000 or 0100000 respectively; rs2 = zero-extended shamt imm[4:0].
- Any other opcode or bad funct7: illegal=1, mode=ALU_OP_ADD, rs1=rs2=0, rd_addr=0. The slot still occupies a handshake.
- Reset asserted mid-transfer discards the slot; no register write from that cycle is retained.

Test Plan:
- Write x1=18 and x2=12 via wb. Accept 0x002081B3 (add x3,x1,x2) -> next cycle out_valid=1, rs1=18, rs2=12, mode=ALU_OP_ADD, rd_addr=3, illegal=0.
- Accept 0x402081B3 (sub) in the same cycle that wb writes x2=5 -> rs1=18, rs2=5 (bypass), mode=ALU_OP_SUB.
- Accept 0xFFF00293 (addi x5,x0,-1) -> rs1=0, rs2=0xFFFFFFFF, mode=ALU_OP_ADD, rd_addr=5. Accept 0x4010D213 (srai x4,x1,1) -> rs2=1, mode=ALU_OP_SRA.
- Hold out_ready=0 after accepting the add, then write x1=7 -> rs1 changes to 7, in_ready=0, a second instruction is not accepted. Raise out_ready with in_valid=1 -> back-to-back reload with out_valid staying 1.
- Accept 0x00000000, and separately funct7=0100000 with funct3=100 -> illegal=1, rs1=rs2=0, rd_addr=0. Write x0=99, then read x0 -> 0.
- Assert reset while out_valid=1 -> out_valid=0 and all registers read 0 afterward.

Source files
------------

// File: rtl/alu_decode_stage.sv
// Decode/operand-fetch stage for RV32I OP and OP-IMM instructions.
// It owns a 32-entry register file and a single output slot that is handed to the ALU.
`ifndef ALU_OP_ADD
`define ALU_OP_ADD  4'd0
`endif
`ifndef ALU_OP_SUB
`define ALU_OP_SUB  4'd1
`endif
`ifndef ALU_OP_SLL
`define ALU_OP_SLL  4'd2
`endif
`ifndef ALU_OP_SLT
`define ALU_OP_SLT  4'd3
`endif
`ifndef ALU_OP_SLTU
`define ALU_OP_SLTU 4'd4
`endif
`ifndef ALU_OP_XOR
`define ALU_OP_XOR  4'd5
`endif
`ifndef ALU_OP_SRL
`define ALU_OP_SRL  4'd6
`endif
`ifndef ALU_OP_SRA
`define ALU_OP_SRA  4'd7
`endif
`ifndef ALU_OP_OR
`define ALU_OP_OR   4'd8
`endif
`ifndef ALU_OP_AND
`define ALU_OP_AND  4'd9
`endif

module alu_decode_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] rs2,
  output logic [3:0]      mode,
  output logic [4:0]      rd_addr,
  output logic            illegal,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       alt;
  logic       accept;
  logic       drain;
  logic       wb_hit;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign alt    = (funct7 == 7'b0100000);

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;
  assign wb_hit   = wb_en && (wb_addr != 5'd0);

  // Register file: x0 is never written, so its entry stays at the reset value of zero.
  logic [XLEN-1:0] regs_q [NREG];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wb_hit) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  logic [4:0]      rd_idx [2];
  logic [XLEN-1:0] rd_val [2];

  assign rd_idx[0] = instr[19:15];
  assign rd_idx[1] = instr[24:20];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_read
      assign rd_val[gi] = (rd_idx[gi] == 5'd0)                  ? '0 :
                          (wb_en && (wb_addr == rd_idx[gi]))     ? wb_data :
                          regs_q[rd_idx[gi]];
    end
  endgenerate

  logic [XLEN-1:0] dec_rs1, dec_rs2;
  logic [3:0]      dec_mode;
  logic [4:0]      dec_rd, dec_src1, dec_src2;
  logic            dec_ill, dec_src2_reg;

  always_comb begin
    dec_ill      = 1'b0;
    dec_mode     = `ALU_OP_ADD;
    dec_rs1      = rd_val[0];
    dec_rs2      = rd_val[1];
    dec_rd       = instr[11:7];
    dec_src1     = instr[19:15];
    dec_src2     = instr[24:20];
    dec_src2_reg = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_src2_reg = 1'b1;
        case (funct3)
          3'b000:  dec_mode = alt ? `ALU_OP_SUB : `ALU_OP_ADD;
          3'b001:  dec_mode = `ALU_OP_SLL;
          3'b010:  dec_mode = `ALU_OP_SLT;
          3'b011:  dec_mode = `ALU_OP_SLTU;
          3'b100:  dec_mode = `ALU_OP_XOR;
          3'b101:  dec_mode = alt ? `ALU_OP_SRA : `ALU_OP_SRL;
          3'b110:  dec_mode = `ALU_OP_OR;
          default: dec_mode = `ALU_OP_AND;
        endcase
        if (!((funct7 == 7'd0) || (alt && (funct3 == 3'b000 || funct3 == 3'b101))))
          dec_ill = 1'b1;
      end
      OPC_OPIMM: begin
        dec_rs2 = {{(XLEN-12){instr[31]}}, instr[31:20]};
        case (funct3)
          3'b000:  dec_mode = `ALU_OP_ADD;
          3'b001: begin
            dec_mode = `ALU_OP_SLL;
            dec_rs2  = {{(XLEN-5){1'b0}}, instr[24:20]};
            dec_ill  = (funct7 != 7'd0);
          end
          3'b010:  dec_mode = `ALU_OP_SLT;
          3'b011:  dec_mode = `ALU_OP_SLTU;
          3'b100:  dec_mode = `ALU_OP_XOR;
          3'b101: begin
            dec_mode = alt ? `ALU_OP_SRA : `ALU_OP_SRL;
            dec_rs2  = {{(XLEN-5){1'b0}}, instr[24:20]};
            dec_ill  = !((funct7 == 7'd0) || alt);
          end
          3'b110:  dec_mode = `ALU_OP_OR;
          default: dec_mode = `ALU_OP_AND;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
    // Illegal slots carry no operands, so zeroed source indices also disable hazard updates.
    if (dec_ill) begin
      dec_mode     = `ALU_OP_ADD;
      dec_rs1      = '0;
      dec_rs2      = '0;
      dec_rd       = 5'd0;
      dec_src1     = 5'd0;
      dec_src2     = 5'd0;
      dec_src2_reg = 1'b0;
    end
  end

  logic            valid_q, valid_d;
  logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic [3:0]      mode_q, mode_d;
  logic [4:0]      rd_q, rd_d, src1_q, src1_d, src2_q, src2_d;
  logic            illegal_q, illegal_d, src2_reg_q, src2_reg_d;

  always_comb begin
    valid_d    = valid_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    mode_d     = mode_q;
    rd_d       = rd_q;
    illegal_d  = illegal_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    src2_reg_d = src2_reg_q;
    if (accept) begin
      valid_d    = 1'b1;
      rs1_d      = dec_rs1;
      rs2_d      = dec_rs2;
      mode_d     = dec_mode;
      rd_d       = dec_rd;
      illegal_d  = dec_ill;
      src1_d     = dec_src1;
      src2_d     = dec_src2;
      src2_reg_d = dec_src2_reg;
    end else if (drain) begin
      valid_d = 1'b0;
    end else if (valid_q && wb_hit) begin
      // A held slot tracks writebacks so the ALU never sees a stale operand.
      if (wb_addr == src1_q) rs1_d = wb_data;
      if (src2_reg_q && (wb_addr == src2_q)) rs2_d = wb_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      mode_q     <= `ALU_OP_ADD;
      rd_q       <= 5'd0;
      illegal_q  <= 1'b0;
      src1_q     <= 5'd0;
      src2_q     <= 5'd0;
      src2_reg_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      mode_q     <= mode_d;
      rd_q       <= rd_d;
      illegal_q  <= illegal_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      src2_reg_q <= src2_reg_d;
    end
  end

  assign out_valid = valid_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign mode      = mode_q;
  assign rd_addr   = rd_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: directed literal cases followed by randomized traffic,
// all checked against a behavioural model of the stage and its register file.
module tb_alu_decode_stage;

  localparam logic [3:0] M_ADD = 4'd0, M_SUB = 4'd1, M_SLL = 4'd2, M_SLT = 4'd3, M_SLTU = 4'd4;
  localparam logic [3:0] M_XOR = 4'd5, M_SRL = 4'd6, M_SRA = 4'd7, M_OR = 4'd8, M_AND = 4'd9;
  localparam logic [3:0] BASE [8] = '{M_ADD, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_OR, M_AND};

  logic        clk;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, illegal, wb_en;
  logic [31:0] instr, rs1, rs2, wb_data;
  logic [3:0]  mode;
  logic [4:0]  rd_addr, wb_addr;

  int n_checks = 0;
  int n_errors = 0;

  alu_decode_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready), .rs1(rs1), .rs2(rs2), .mode(mode),
    .rd_addr(rd_addr), .illegal(illegal), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  mode;
    logic [4:0]  rd;
    logic        ill;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic        s2reg;
  } slot_t;

  logic [31:0] m_regs [32];
  logic        m_valid = 1'b0;
  slot_t       m_slot;

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (wb_en && wb_addr == idx) return wb_data;
    return m_regs[idx];
  endfunction

  function automatic slot_t model_decode(input logic [31:0] w);
    slot_t      s;
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    bit         ok;
    op = w[6:0]; f7 = w[31:25]; f3 = w[14:12];
    s.rd = w[11:7]; s.s1 = w[19:15]; s.s2 = w[24:20];
    s.a = model_read(s.s1); s.b = 32'd0; s.s2reg = 1'b0; s.mode = M_ADD; s.ill = 1'b0;
    ok = 1'b0;
    if (op == 7'h33) begin
      s.s2reg = 1'b1;
      s.b = model_read(s.s2);
      if (f7 == 7'h00) begin ok = 1'b1; s.mode = BASE[f3]; end
      else if (f7 == 7'h20 && f3 == 3'd0) begin ok = 1'b1; s.mode = M_SUB; end
      else if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1'b1; s.mode = M_SRA; end
    end else if (op == 7'h13) begin
      ok = 1'b1;
      s.mode = BASE[f3];
      s.b = 32'($signed(w[31:20]));
      if (f3 == 3'd1 || f3 == 3'd5) begin
        s.b = 32'(w[24:20]);
        if (f7 == 7'h20 && f3 == 3'd5) s.mode = M_SRA;
        else if (f7 != 7'h00) ok = 1'b0;
      end
    end
    if (!ok) begin
      s = '0;
      s.mode = M_ADD;
    end
    s.ill = !ok;
    return s;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
    end else begin
      if (in_valid && (!m_valid || out_ready)) begin
        m_slot  <= model_decode(instr);
        m_valid <= 1'b1;
        $display("t=%0t accept instr=%h", $time, instr);
      end else if (m_valid && out_ready) begin
        m_valid <= 1'b0;
      end else if (m_valid && wb_en && wb_addr != 5'd0) begin
        if (wb_addr == m_slot.s1) m_slot.a <= wb_data;
        if (m_slot.s2reg && wb_addr == m_slot.s2) m_slot.b <= wb_data;
      end
      if (wb_en && wb_addr != 5'd0) m_regs[wb_addr] <= wb_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      check("reset out_valid", 32'(out_valid), 32'd0);
    end else begin
      check("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
      check("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        check("rs1", rs1, m_slot.a);
        check("rs2", rs2, m_slot.b);
        check("mode", 32'(mode), 32'(m_slot.mode));
        check("rd_addr", 32'(rd_addr), 32'(m_slot.rd));
        check("illegal", 32'(illegal), 32'(m_slot.ill));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic send(input logic [31:0] w);
    instr = w; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_slot(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] m, input logic [4:0] rd, input logic ill);
    check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    check({tag, " rs1"}, rs1, a);
    check({tag, " rs2"}, rs2, b);
    check({tag, " mode"}, 32'(mode), 32'(m));
    check({tag, " rd_addr"}, 32'(rd_addr), 32'(rd));
    check({tag, " illegal"}, 32'(illegal), 32'(ill));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] op, f7;
    int         k;
    k = $urandom_range(0, 9);
    op = (k < 4) ? 7'h33 : (k < 8) ? 7'h13 : 7'($urandom);
    k = $urandom_range(0, 3);
    f7 = (k == 1) ? 7'h20 : (k == 3) ? 7'($urandom) : 7'h00;
    if ($urandom_range(0, 30) == 0) return 32'd0;
    return {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom),
            5'($urandom_range(0, 7)), op};
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; instr = 32'd0;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    tick(); tick();
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst rs1", rs1, 32'd0);
    check("rst rs2", rs2, 32'd0);
    check("rst mode", 32'(mode), 32'(M_ADD));
    check("rst rd_addr", 32'(rd_addr), 32'd0);
    check("rst illegal", 32'(illegal), 32'd0);
    reset = 1'b0;
    tick();

    wb_write(5'd1, 32'd18);
    wb_write(5'd2, 32'd12);
    send(32'h002081B3);
    expect_slot("add", 32'd18, 32'd12, M_ADD, 5'd3, 1'b0);
    tick();

    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'd5;
    send(32'h402081B3);
    wb_en = 1'b0;
    expect_slot("sub bypass", 32'd18, 32'd5, M_SUB, 5'd3, 1'b0);
    tick();

    send(32'hFFF00293);
    expect_slot("addi", 32'd0, 32'hFFFFFFFF, M_ADD, 5'd5, 1'b0);
    send(32'h4010D213);
    expect_slot("srai", 32'd18, 32'd1, M_SRA, 5'd4, 1'b0);
    tick();

    // Hold the slot, let a writeback hit rs1, then release into a back-to-back reload.
    instr = 32'h002081B3; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    expect_slot("hold add", 32'd18, 32'd5, M_ADD, 5'd3, 1'b0);
    instr = 32'h402081B3;
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd7;
    #1;
    check("hold in_ready", 32'(in_ready), 32'd0);
    tick();
    wb_en = 1'b0;
    expect_slot("hazard", 32'd7, 32'd5, M_ADD, 5'd3, 1'b0);
    out_ready = 1'b1;
    #1;
    check("release in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    expect_slot("reload", 32'd7, 32'd5, M_SUB, 5'd3, 1'b0);
    tick();
    check("drained", 32'(out_valid), 32'd0);

    send(32'h00000000);
    expect_slot("zero word", 32'd0, 32'd0, M_ADD, 5'd0, 1'b1);
    send(32'h4020C1B3);
    expect_slot("bad funct7", 32'd0, 32'd0, M_ADD, 5'd0, 1'b1);
    tick();
    wb_write(5'd0, 32'd99);
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'd99;
    send(32'h000001B3);
    wb_en = 1'b0;
    expect_slot("read x0", 32'd0, 32'd0, M_ADD, 5'd3, 1'b0);
    tick();

    instr = 32'h002081B3; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check("pre-reset valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd55;
    #1;
    check("async reset valid", 32'(out_valid), 32'd0);
    tick();
    reset = 1'b0; wb_en = 1'b0;
    tick();
    send(32'h002081B3);
    expect_slot("after reset", 32'd0, 32'd0, M_ADD, 5'd3, 1'b0);
    tick();

    for (int n = 0; n < 1500; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      instr     = rand_instr();
      wb_en     = $urandom_range(0, 1) == 1;
      wb_addr   = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end else begin
        tick();
      end
    end
    in_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
